// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared widths and FSM state type for the data memory responder
package mem_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - single-port word RAM, synchronous write and synchronous read
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_W-1:0] rdata_q;

    // Contents are deliberately never reset; the read register only moves on a read.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[idx_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[idx_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - fixed-latency data memory responder for the CPU MEM stage
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int LATENCY     = 3,
    parameter int DEPTH_WORDS = 256
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              ack_o,
    output logic              err_o,
    output logic              busy_o
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LOAD = 4'((LATENCY > 1) ? (LATENCY - 2) : 0);

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               bad_q, bad_d;
    logic               zero_q, zero_d;

    logic               accept, enter_resp, addr_bad;
    logic               acc_we, acc_bad, ram_en;
    logic [IDX_W-1:0]   acc_idx;
    logic [DATA_W-1:0]  acc_wdata, ram_rdata;

    assign addr_bad = (addr_i[1:0] != 2'b00) || ((addr_i >> (IDX_W + 2)) != '0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        bad_d      = bad_q;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    accept  = 1'b1;
                    we_d    = we_i;
                    idx_d   = addr_i[IDX_W+1:2];
                    wdata_d = wdata_i;
                    bad_d   = addr_bad;
                    if (LATENCY == 1) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With LATENCY=1 the RAM is accessed in the accept cycle, before the request is latched.
    always_comb begin
        acc_we    = accept ? we_i : we_q;
        acc_idx   = accept ? addr_i[IDX_W+1:2] : idx_q;
        acc_wdata = accept ? wdata_i : wdata_q;
        acc_bad   = accept ? addr_bad : bad_q;
        ram_en    = enter_resp && !acc_bad && rst_n_i;
        zero_d    = zero_q;
        if (enter_resp) begin
            zero_d = acc_bad ? 1'b1 : (acc_we ? zero_q : 1'b0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            bad_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            bad_q   <= bad_d;
            zero_q  <= zero_d;
        end
    end

    mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_mem_array (
        .clk_i   (clk_i),
        .en_i    (ram_en),
        .we_i    (acc_we),
        .idx_i   (acc_idx),
        .wdata_i (acc_wdata),
        .rdata_o (ram_rdata)
    );

    // zero_q masks the RAM read register after reset and after an illegal access.
    assign rdata_o = zero_q ? '0 : ram_rdata;
    assign ack_o   = (state_q == RESP);
    assign err_o   = ack_o && bad_q;
    assign busy_o  = ((state_q == IDLE) && req_i) || (state_q == WAIT);

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder at LATENCY 3 and 1
module tb_data_mem_responder;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_a, we_a, ack_a, err_a, busy_a;
    logic [31:0] addr_a, wdata_a, rdata_a;
    logic        req_b, we_b, ack_b, err_b, busy_b;
    logic [31:0] addr_b, wdata_b, rdata_b;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    data_mem_responder #(.LATENCY(3), .DEPTH_WORDS(256)) u_dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req_a), .we_i(we_a), .addr_i(addr_a),
        .wdata_i(wdata_a), .rdata_o(rdata_a), .ack_o(ack_a), .err_o(err_a), .busy_o(busy_a)
    );

    data_mem_responder #(.LATENCY(1), .DEPTH_WORDS(256)) u_dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req_b), .we_i(we_b), .addr_i(addr_b),
        .wdata_i(wdata_b), .rdata_o(rdata_b), .ack_o(ack_b), .err_o(err_b), .busy_o(busy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic score(input bit on_b, input logic [31:0] rd, input logic err, input logic busy);
        exp_t e;
        if ((on_b ? qb.size() : qa.size()) == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack_%s: got ack with nothing outstanding, expected none (cycle %0d)",
                     on_b ? "b" : "a", cyc);
            return;
        end
        e = on_b ? qb.pop_front() : qa.pop_front();
        chk(on_b ? "b_ack_cycle" : "a_ack_cycle", cyc, e.cyc);
        chk(on_b ? "b_err" : "a_err", err, e.err);
        chk(on_b ? "b_rdata" : "a_rdata", rd, e.rd);
        chk(on_b ? "b_busy_on_ack" : "a_busy_on_ack", busy, 1'b0);
    endtask

    always @(negedge clk) begin
        if (ack_a) score(1'b0, rdata_a, err_a, busy_a);
        else if (err_a) chk("a_err_without_ack", err_a, 1'b0);
        if (ack_b) score(1'b1, rdata_b, err_b, busy_b);
        else if (err_b) chk("b_err_without_ack", err_b, 1'b0);
    end

    task automatic drive(input bit on_b, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (on_b) begin
            req_b = req; we_b = we; addr_b = addr; wdata_b = wdata;
        end else begin
            req_a = req; we_a = we; addr_a = addr; wdata_a = wdata;
        end
    endtask

    task automatic push(input bit on_b, input logic [31:0] rd, input logic err, input int at);
        exp_t e;
        e.rd  = rd;
        e.err = err;
        e.cyc = at;
        if (on_b) qb.push_back(e);
        else      qa.push_back(e);
    endtask

    task automatic drain(input bit on_b);
        for (int n = 0; n < 40; n++) begin
            if ((on_b ? qb.size() : qa.size()) == 0) break;
            @(posedge clk);
        end
        if ((on_b ? qb.size() : qa.size()) != 0) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout_%s: got no ack within 40 cycles, expected ack", on_b ? "b" : "a");
            if (on_b) qb.delete();
            else      qa.delete();
        end
    endtask

    task automatic access(input bit on_b, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err);
        int lat;
        lat = on_b ? 1 : 3;
        @(posedge clk); #1;
        drive(on_b, 1'b1, we, addr, wdata);
        push(on_b, exp_rd, exp_err, cyc + lat);
        #1 chk(on_b ? "b_busy_accept" : "a_busy_accept", on_b ? busy_b : busy_a, 1'b1);
        @(posedge clk); #1;
        drive(on_b, 1'b0, 1'b0, 32'h0, 32'h0);
        drain(on_b);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack_a", ack_a, 1'b0);
        chk("rst_err_a", err_a, 1'b0);
        chk("rst_rdata_a", rdata_a, 32'h0);
        chk("rst_busy_a", busy_a, 1'b0);
        chk("rst_ack_b", ack_b, 1'b0);
        chk("rst_rdata_b", rdata_b, 32'h0);
        req_a = 1'b1;
        #1 chk("rst_busy_follows_req", busy_a, 1'b1);
        req_a = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // LATENCY=3: basic write/read, illegal accesses, suppressed writes
        access(1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0);
        access(1'b0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
        access(1'b0, 1'b1, 32'h4,   32'h0BADF00D, 32'hDEADBEEF, 1'b0);
        access(1'b0, 1'b0, 32'h6,   32'h0,        32'h0,        1'b1);
        access(1'b0, 1'b0, 32'h400, 32'h0,        32'h0,        1'b1);
        access(1'b0, 1'b1, 32'h404, 32'hFFFFFFFF, 32'h0,        1'b1);
        access(1'b0, 1'b1, 32'h12,  32'hFFFFFFFF, 32'h0,        1'b1);
        access(1'b0, 1'b0, 32'h4,   32'h0,        32'h0BADF00D, 1'b0);
        access(1'b0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);

        // req held high through WAIT and RESP: second accept only once back in IDLE
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
        c = cyc;
        push(1'b0, 32'hDEADBEEF, 1'b0, c + 3);
        push(1'b0, 32'hDEADBEEF, 1'b0, c + 7);
        repeat (4) @(posedge clk);
        #1 chk("a_busy_second_accept", busy_a, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drain(1'b0);

        // reset in WAIT of a write: aborted, no ack, old contents kept
        access(1'b0, 1'b1, 32'h20, 32'h11111111, 32'hDEADBEEF, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b1, 32'h20, 32'hAAAA5555);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1 chk("a_busy_in_wait", busy_a, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("a_midrst_ack", ack_a, 1'b0);
        chk("a_midrst_err", err_a, 1'b0);
        chk("a_midrst_rdata", rdata_a, 32'h0);
        chk("a_midrst_busy_idle", busy_a, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk("a_idle_after_rst", busy_a, 1'b0);
        access(1'b0, 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0);

        // LATENCY=1
        access(1'b1, 1'b1, 32'h0,   32'h12345678, 32'h0,        1'b0);
        access(1'b1, 1'b0, 32'h0,   32'h0,        32'h12345678, 1'b0);
        access(1'b1, 1'b1, 32'h3FC, 32'hCAFEF00D, 32'h12345678, 1'b0);
        access(1'b1, 1'b0, 32'h3FC, 32'h0,        32'hCAFEF00D, 1'b0);
        access(1'b1, 1'b0, 32'h400, 32'h0,        32'h0,        1'b1);
        access(1'b1, 1'b0, 32'h0,   32'h0,        32'h12345678, 1'b0);
        #1 chk("b_busy_after_ack", busy_b, 1'b0);

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 3, meaning cycles from the request-accept cycle to the ack cycle; legal range 1..15.
REQ-002 SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit words stored; must be a power of two.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port req_i, input, 1 bit: the CPU MEM stage requests an access.
REQ-006 SHALL have port we_i, input, 1 bit: 1 = write, 0 = read.
REQ-007 SHALL have port addr_i, input, 32 bits: byte address.
REQ-008 SHALL have port wdata_i, input, 32 bits: write data.
REQ-009 SHALL have port rdata_o, output, 32 bits: read data, held until the next ack.
REQ-010 SHALL have port ack_o, output, 1 bit: one-cycle pulse marking completion.
REQ-011 SHALL have port err_o, output, 1 bit: pulses with ack_o when the access was illegal.
REQ-012 SHALL have port busy_o, output, 1 bit: stall to the CPU (PC, IF/ID and pipeline-register hold).

Function
REQ-013 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-014 SHALL accept a request only when state is IDLE and req_i=1, latching we_i, addr_i and wdata_i at that edge.
REQ-015 SHALL, on accept with LATENCY=1, go IDLE->RESP; with LATENCY>1, go IDLE->WAIT and load the down-counter with LATENCY-2.
REQ-016 SHALL, in WAIT, decrement the counter each cycle and go to RESP on the edge where the counter is 0.
REQ-017 SHALL assert ack_o for exactly the one cycle spent in RESP, and always go RESP->IDLE.
REQ-018 SHALL place ack_o exactly LATENCY cycles after the accept cycle.
REQ-019 SHALL drive busy_o combinationally = (IDLE and req_i) or WAIT; busy_o SHALL be 0 in RESP, so the CPU advances on the ack cycle.
REQ-020 SHALL ignore req_i in WAIT and RESP; the CPU deasserts or changes req_i in the ack cycle, and back-to-back accesses are spaced LATENCY+1 cycles apart.
REQ-021 SHALL perform the write, or capture the read word into rdata_o, at the edge entering RESP.
REQ-022 SHALL use word index = addr[log2(DEPTH_WORDS)+1:2].
REQ-023 SHALL treat an access as illegal if addr[1:0]!=0 or addr[31:log2(DEPTH_WORDS)+2]!=0.
REQ-024 SHALL, for an illegal access, assert err_o with ack_o, suppress the write, and set rdata_o=0.
REQ-025 SHALL leave rdata_o unchanged after a write ack.
REQ-026 SHALL make a write-then-read to the same address return the new data.

Reset
REQ-027 SHALL, while rst_n_i=0 (asynchronous), force state=IDLE, counter=0, ack_o=0, err_o=0 and rdata_o=0; busy_o SHALL follow REQ-019.
REQ-028 SHALL, on reset mid-transaction, abort the transaction, never perform the pending write and never emit an ack.
REQ-029 SHALL not reset the memory contents.

Structure
REQ-030 SHALL take from shared package mem_pkg: the state enum (IDLE/WAIT/RESP) and constants DATA_W=32 and ADDR_W=32.
REQ-031 SHALL instantiate one sub-module, mem_array: a single-port, synchronous-write, synchronous-read word RAM with parameter DEPTH_WORDS.

Verification
REQ-032 SHALL cover: LATENCY=3, write 0xDEADBEEF to 0x10, then read 0x10 -> ack on cycle 3 after each accept, rdata_o=0xDEADBEEF, err_o=0.
REQ-033 SHALL cover: LATENCY=1, read 0x0 after a write of 0x12345678 -> ack the cycle after accept, busy_o high only in the accept cycle.
REQ-034 SHALL cover: read 0x6 (misaligned) and read 0x400 (out of range at 256 words) -> err_o=1 with ack_o, rdata_o=0, memory unchanged.
REQ-035 SHALL cover: req_i held high through WAIT and RESP -> exactly one ack, with the next accept no earlier than LATENCY+1 cycles after the first.
REQ-036 SHALL cover: rst_n_i pulsed low in WAIT of a write of 0xAAAA5555 to 0x20 -> no ack, state IDLE, and a later read of 0x20 returns its prior value.
